// File: rtl/data_ram_pkg.sv
// rtl/data_ram_pkg.sv - shared constants and state encoding for the data RAM responder
package data_ram_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  localparam int DataAddrBusW = 32;
  localparam int DataBusW     = 32;
  localparam int ByteSelBusW  = 4;

  typedef enum logic [1:0] {
    DRAM_IDLE = 2'd0,
    DRAM_WAIT = 2'd1,
    DRAM_ACK  = 2'd2
  } dram_state_t;

endpackage

// File: rtl/data_ram_array.sv
// rtl/data_ram_array.sv - four byte-wide banks, per-lane synchronous write, registered word read
module data_ram_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int Depth = 2 ** ADDR_WIDTH;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem [Depth];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (we[g]) mem[addr] <= wdata[8*g +: 8];
      if (re)    q <= mem[addr];
    end

    assign rdata[8*g +: 8] = q;
  end

endmodule

// File: rtl/data_ram.sv
// rtl/data_ram.sv - data-memory responder: ce/ack handshake, configurable latency, error check
module data_ram
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "data_ram: LATENCY must be in 1..15");
  end

  dram_state_t state, state_n;
  logic [3:0]  cnt;
  logic        we_q;
  logic [29:0] word_q;
  logic [3:0]  sel_q;
  logic [31:0] wdata_q;
  logic [31:0] hold_q;
  logic        err_q;
  logic        err_now;
  logic        access;
  logic [31:0] rdata;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];

  assign err_now = (sel_q == 4'b0000) || ((word_q >> ADDR_WIDTH) != 30'd0);
  // A reset landing on the access edge must suppress the write.
  assign access  = (state == DRAM_WAIT) && (cnt == 4'd0) && (rst != RstEnable);

  data_ram_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .we    ((access && we_q == WriteEnable && !err_now) ? sel_q : 4'b0000),
    .re    (access && we_q != WriteEnable && !err_now),
    .addr  (word_q[ADDR_WIDTH-1:0]),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  always_comb begin
    state_n = state;
    case (state)
      DRAM_IDLE: if (ce_i == ChipEnable) state_n = DRAM_WAIT;
      DRAM_WAIT: if (cnt == 4'd0) state_n = DRAM_ACK;
      DRAM_ACK:  state_n = DRAM_IDLE;
      default:   state_n = DRAM_IDLE;
    endcase
  end

  always_comb begin
    ack_o  = (state == DRAM_ACK);
    err_o  = ack_o && err_q;
    data_o = hold_q;
    if (ack_o) begin
      if (err_q)                   data_o = ZeroWord;
      else if (we_q != WriteEnable) data_o = rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state  <= DRAM_IDLE;
      cnt    <= 4'd0;
      hold_q <= ZeroWord;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        DRAM_IDLE: if (ce_i == ChipEnable) cnt <= 4'(LATENCY - 1);
        DRAM_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             err_q <= err_now;
        end
        DRAM_ACK:  hold_q <= data_o;
        default:   cnt <= 4'd0;
      endcase
    end
  end

  // Request fields are sampled only when a request is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (state == DRAM_IDLE && ce_i == ChipEnable) begin
      we_q    <= we_i;
      word_q  <= addr_i[31:2];
      sel_q   <= sel_i;
      wdata_q <= data_i;
    end
  end

endmodule

// File: doc/data_ram.md
Name: data_ram

Overview:
- Data-memory responder at the far end of the MEM-stage load/store interface: MEM stage initiates, data_ram accepts, performs the access and acknowledges.
- Word-organised synchronous RAM with byte-lane write enables and a ce/ack handshake.
- Access latency is configurable so the pipeline stall path is exercised.
- Sits beside inst_rom inside sopc and is driven by the core's data-memory port.

Parameters:
- ADDR_WIDTH, 10, word-address width; depth = 2**ADDR_WIDTH words.
- LATENCY, 1, wait cycles between request acceptance and the access; legal range 1..15.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- ce_i  input  1  request valid; held with all request fields stable until ack_o.
- we_i  input  1  1 = store, 0 = load.
- addr_i  input  32  byte address; bits [1:0] ignored, bits [ADDR_WIDTH+1:2] select the word.
- sel_i  input  4  byte-lane enables; sel_i[k] covers data bits [8k+7:8k].
- data_i  input  32  store data.
- data_o  output  32  load data, valid while ack_o=1.
- ack_o  output  1  one-cycle completion pulse.
- err_o  output  1  request rejected; valid while ack_o=1.

Behaviour:
- Reset:
  - rst=1 at an edge forces state IDLE, wait counter 0, and ack_o=0, err_o=0, data_o=0x00000000 from the next cycle.
  - RAM contents are not cleared.
- States: IDLE, WAIT, ACK.
- IDLE:
  - If ce_i=1, capture we_i/addr_i/sel_i/data_i, load counter = LATENCY-1 and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If counter != 0, decrement it.
  - If counter == 0, perform the access using the captured fields and go to ACK.
  - Inputs are ignored in WAIT; only captured values are used, including if ce_i drops early.
- ACK:
  - ack_o=1 for exactly one cycle; data_o and err_o are valid.
  - Unconditionally return to IDLE.
  - The requester must deassert ce_i in the cycle after ack_o, or that cycle's ce_i is taken as a new request.
- Timing: ce_i first seen high in IDLE at cycle N gives ack_o=1 in cycle N+LATENCY+1. Peak throughput is one request per LATENCY+2 cycles.
- Outputs outside ACK: ack_o=0 and err_o=0. data_o holds its last value (0 after reset).
- Error check, evaluated on the captured fields at the access edge:
  - err is set if sel=4'b0000, or if any of addr[31:ADDR_WIDTH+2] is 1 (out of range).
  - On err: no write occurs, data_o=0x00000000, err_o=1, ack_o=1.
- Store: for each k with sel[k]=1, byte lane k of word addr[ADDR_WIDTH+1:2] is written with data[8k+7:8k]. Other lanes are unchanged. data_o is unchanged on a store ack.
- Load: data_o = the full stored word. sel only participates in the error check.
- Read-after-write: a load accepted after a store's ack returns the updated data; there is no bypass requirement inside one access.
- Reset mid-operation: rst asserted in WAIT aborts the request with no write and no ack. rst in ACK clears ack_o at the next edge.
- Simultaneous rst and ce_i: rst wins and the request is dropped.
- LATENCY is checked at elaboration; a value outside 1..15 is a fatal error. The counter is 4 bits.

Decomposition:
- Shared defines header holds:
  - `RstEnable, `ZeroWord, `ChipEnable, `WriteEnable.
  - `DataAddrBus 31:0, `DataBus 31:0, `ByteSelBus 3:0.
  - State encodings `DRamIdle/`DRamWait/`DRamAck.
- One sub-module, data_ram_array: four byte-wide bank arrays with synchronous per-lane write and registered word read. It contains no reset and no handshake logic. data_ram owns the FSM, the counter, capture registers and the error check.

Test Plan:
- LATENCY=1, reset, then store addr 0x00000010 sel 4'b1111 data 0xDEADBEEF -> ack_o in cycle N+2, err_o=0. Then load 0x10 -> data_o=0xDEADBEEF with ack_o.
- Byte lanes: store 0x11223344 full to 0x20, store sel 4'b0010 data 0x0000AA00 -> load 0x20 returns 0x1122AA44. Store sel 4'b1100 data 0x55660000 -> load returns 0x5566AA44.
- LATENCY=4: load request -> ack_o exactly 5 cycles after ce_i seen, single-cycle pulse. ce_i held high after ack -> second ack follows 6 cycles after the first.
- Errors, ADDR_WIDTH=10:
  - Load addr 0x00001000 -> ack_o=1, err_o=1, data_o=0.
  - Store with sel 4'b0000 -> err_o=1 and a memory readback shows the word unchanged.
- Reset mid-op, LATENCY=4: store issued, rst pulsed in the second WAIT cycle -> no ack; a later load of that address returns the old value. Outputs read 0 the cycle after rst.
- ce_i dropped during WAIT and addr_i changed -> access completes at the originally captured address.
